// File: rtl/lc3_instr_encoder_if.sv
// Request/response bus of the LC-3 instruction encoder.
// The master side supplies encode requests and consumes instruction words;
// the slave side is the encoder itself.
interface lc3_instr_encoder_if;
    // Request channel
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] value;

    // Instruction word channel
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid,
        output fmt,
        output opcode,
        output dr,
        output sr1,
        output sr2,
        output value,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  fmt,
        input  opcode,
        input  dr,
        input  sr1,
        input  sr2,
        input  value,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_err
    );
endinterface

// File: rtl/lc3_instr_encoder.sv
// LC-3 instruction encoder: packs opcode, register fields and a 16-bit signed
// operand into one instruction word, narrowing the operand to the field width
// of the chosen format with a range check. Two registered stages with a
// valid/ready handshake; range/format errors are counted (saturating).
module lc3_instr_encoder #(
    parameter int unsigned ERR_CNT_W = 8,
    parameter bit          STRICT    = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    lc3_instr_encoder_if.slave   bus,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FmtReg     = 3'd0;
    localparam logic [2:0] FmtImm5    = 3'd1;
    localparam logic [2:0] FmtOff6    = 3'd2;
    localparam logic [2:0] FmtOff9    = 3'd3;
    localparam logic [2:0] FmtOff11   = 3'd4;
    localparam logic [2:0] FmtTrap    = 3'd5;
    localparam logic [2:0] FmtNot     = 3'd6;
    localparam logic [2:0] FmtIllegal = 3'd7;

    // Handshake / control
    logic in_err;
    logic keep_req;
    logic accept;
    logic s2_free;
    logic s2_load;
    logic in_ready_w;
    logic rdy_q;

    // Stage 1: registered request (only the operand bits any format can use)
    logic        s1_valid_q;
    logic [2:0]  s1_fmt_q;
    logic [3:0]  s1_opcode_q;
    logic [2:0]  s1_dr_q;
    logic [2:0]  s1_sr1_q;
    logic [2:0]  s1_sr2_q;
    logic [10:0] s1_value_q;
    logic        s1_err_q;

    // Stage 2: registered instruction word
    logic [15:0] enc_instr;
    logic        s2_valid_q;
    logic [15:0] s2_instr_q;
    logic        s2_err_q;

    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Range/format check of the incoming request; the operand fits a field of
    // width N when bits [15:N-1] are all equal (TRAP is unsigned 8-bit).
    always_comb begin
        in_err = 1'b0;
        case (bus.fmt)
            FmtImm5:    in_err = !(&bus.value[15:4]  || !(|bus.value[15:4]));
            FmtOff6:    in_err = !(&bus.value[15:5]  || !(|bus.value[15:5]));
            FmtOff9:    in_err = !(&bus.value[15:8]  || !(|bus.value[15:8]));
            FmtOff11:   in_err = !(&bus.value[15:10] || !(|bus.value[15:10]));
            FmtTrap:    in_err = |bus.value[15:8];
            FmtIllegal: in_err = 1'b1;
            default:    in_err = 1'b0;
        endcase
    end

    // Handshake: stage 1 may load when it is empty or drains into stage 2 in
    // the same cycle; in_ready depends only on state and out_ready.
    always_comb begin
        s2_free    = !s2_valid_q || bus.out_ready;
        s2_load    = s1_valid_q && s2_free;
        in_ready_w = rdy_q && (!s1_valid_q || s2_free);
        accept     = bus.in_valid && in_ready_w;
        // In strict mode an erroneous request never takes a pipeline slot.
        keep_req   = !(STRICT && in_err);
    end

    // Ready gate: keeps in_ready low until the first clock after reset release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Stage 1: capture an accepted request, or empty when it moves to stage 2.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 3'd0;
            s1_opcode_q <= 4'd0;
            s1_dr_q     <= 3'd0;
            s1_sr1_q    <= 3'd0;
            s1_sr2_q    <= 3'd0;
            s1_value_q  <= 11'd0;
            s1_err_q    <= 1'b0;
        end else if (accept) begin
            s1_valid_q  <= keep_req;
            s1_fmt_q    <= bus.fmt;
            s1_opcode_q <= bus.opcode;
            s1_dr_q     <= bus.dr;
            s1_sr1_q    <= bus.sr1;
            s1_sr2_q    <= bus.sr2;
            s1_value_q  <= bus.value[10:0];
            s1_err_q    <= in_err;
        end else if (s2_load) begin
            s1_valid_q  <= 1'b0;
        end
    end

    // Encode the stage-1 request; out-of-range operands keep their low N bits.
    always_comb begin
        enc_instr = 16'h0000;
        case (s1_fmt_q)
            FmtReg:   enc_instr = {s1_opcode_q, s1_dr_q, s1_sr1_q, 3'b000, s1_sr2_q};
            FmtImm5:  enc_instr = {s1_opcode_q, s1_dr_q, s1_sr1_q, 1'b1, s1_value_q[4:0]};
            FmtOff6:  enc_instr = {s1_opcode_q, s1_dr_q, s1_sr1_q, s1_value_q[5:0]};
            FmtOff9:  enc_instr = {s1_opcode_q, s1_dr_q, s1_value_q[8:0]};
            FmtOff11: enc_instr = {s1_opcode_q, 1'b1, s1_value_q[10:0]};
            FmtTrap:  enc_instr = {s1_opcode_q, 4'b0000, s1_value_q[7:0]};
            FmtNot:   enc_instr = {s1_opcode_q, s1_dr_q, s1_sr1_q, 6'b111111};
            default:  enc_instr = 16'h0000;
        endcase
    end

    // Stage 2: output register, held stable while the consumer stalls.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= 16'h0000;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_instr_q <= enc_instr;
            s2_err_q   <= s1_err_q;
        end else if (bus.out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    // Error counter: one step per accepted erroneous request, saturating.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt_q <= '0;
        end else if (accept && in_err && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Output drive.
    always_comb begin
        bus.in_ready  = in_ready_w;
        bus.out_valid = s2_valid_q;
        bus.out_instr = s2_instr_q;
        bus.out_err   = s2_err_q;
        err_count     = err_cnt_q;
    end

endmodule
